// File: rtl/stage_buf_pkg.sv
// Shared core constants and helpers for the pipeline staging buffer.
package stage_buf_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned PC_W     = 32;
  localparam int unsigned OPINFO_W = 16;
  localparam int unsigned IMM_W    = 32;
  localparam int unsigned SYS_W    = 8;

  // Canonical NOP (addi x0, x0, 0) used as the pipeline bubble.
  localparam logic [31:0] NOP_INSN = 32'h13;

  typedef enum logic [1:0] {
    BUF_IDLE = 2'b00,
    BUF_PUSH = 2'b01,
    BUF_POP  = 2'b10,
    BUF_BOTH = 2'b11
  } buf_op_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stage_buf_ptr.sv
// Pointer counter that wraps explicitly from DEPTH-1 back to 0.
module stage_buf_ptr
  import stage_buf_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/stage_buf.sv
// Registered pipeline staging FIFO; drives a bubble value while empty.
module stage_buf
  import stage_buf_pkg::*;
#(
  parameter  int unsigned        DATA_W     = XLEN,
  parameter  int unsigned        DEPTH      = 2,
  parameter  logic [DATA_W-1:0]  BUBBLE_VAL = DATA_W'(NOP_INSN),
  parameter  bit                 RDY_PASS   = 1'b0,
  localparam int unsigned        CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic [CNT_W-1:0]  count_o
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              not_full, push, pop;
  buf_op_e           op;

  assign not_full    = (count_q < CNT_W'(DEPTH));
  // With RDY_PASS a full buffer still accepts when the head is leaving this cycle.
  assign in_ready_o  = (not_full | (RDY_PASS & out_ready_i)) & ~flush_i;
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign op          = buf_op_e'({pop, push});

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      unique case (op)
        BUF_PUSH: count_d = count_q + CNT_W'(1);
        BUF_POP:  count_d = count_q - CNT_W'(1);
        default:  count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr] <= in_data_i;
    end
  end

  stage_buf_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (push),
    .ptr_o (wr_ptr)
  );

  stage_buf_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (pop),
    .ptr_o (rd_ptr)
  );

  assign out_data_o = out_valid_o ? mem_q[rd_ptr] : BUBBLE_VAL;
  assign count_o    = count_q;

endmodule

// File: doc/stage_buf.md
STAGE_BUF -- requirements
Module: stage_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, meaning entry count, legal 1..8.
REQ-003 SHALL have parameter BUBBLE_VAL, default 32'h13 (NOP), meaning the value driven on out_data_o while out_valid_o=0.
REQ-004 SHALL have parameter RDY_PASS, default 0, meaning that when 1, a full buffer accepts input in the same cycle it pops.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port flush_i, input, 1 bit: discards all held entries.
REQ-008 SHALL have port in_valid_i, input, 1 bit: producer offers in_data_i.
REQ-009 SHALL have port in_data_i, input, DATA_W bits: producer payload.
REQ-010 SHALL have port in_ready_o, output, 1 bit: buffer can accept.
REQ-011 SHALL have port out_valid_o, output, 1 bit: head entry present.
REQ-012 SHALL have port out_data_o, output, DATA_W bits: head payload, or BUBBLE_VAL.
REQ-013 SHALL have port out_ready_i, input, 1 bit: consumer takes the head.
REQ-014 SHALL have port count_o, output, $clog2(DEPTH+1) bits: entries held.

Function
REQ-015 SHALL push on in_valid_i & in_ready_o and pop on out_valid_o & out_ready_i, both at the same clock edge.
REQ-016 SHALL present a pushed entry on out_valid_o no earlier than the cycle after the push; there is no combinational data bypass, so latency is 1 cycle.
REQ-017 SHALL drive out_valid_o = (count_o != 0).
REQ-018 SHALL drive out_data_o = the head entry when out_valid_o=1, else BUBBLE_VAL.
REQ-019 SHALL, with RDY_PASS=0, drive in_ready_o = (count_o < DEPTH) & ~flush_i.
REQ-020 SHALL, with RDY_PASS=1, drive in_ready_o = ((count_o < DEPTH) | out_ready_i) & ~flush_i.
REQ-021 SHALL, on a simultaneous push and pop, leave count_o unchanged and preserve FIFO order.
REQ-022 SHALL wrap the read and write pointers explicitly from DEPTH-1 to 0, so DEPTH need not be a power of two.
REQ-023 SHALL, when flush_i=1, set count_o to 0 and both pointers to 0 at the next edge; a pop in the same cycle is permitted but has no further effect.
REQ-024 SHALL hold the head payload stable while out_valid_o=1 and out_ready_i=0.
REQ-025 SHALL never overflow (push while full without pop) or underflow; count_o stays within 0..DEPTH.
REQ-026 SHALL, when DEPTH=1 and RDY_PASS=1, sustain one transfer per cycle.
REQ-027 SHALL, when DEPTH=2 and RDY_PASS=0, sustain one transfer per cycle with in_ready_o registered-only.

Reset
REQ-028 SHALL, while rst_i=1 at an edge, clear count_o and both pointers to 0; rst_i takes priority over flush_i, push and pop.
REQ-029 SHALL, after reset, show out_valid_o=0, out_data_o=BUBBLE_VAL and in_ready_o=1 (when flush_i=0).
REQ-030 SHALL leave storage entries unreset; they are not observable while count_o=0.

Structure
REQ-031 SHALL take the NOP constant (32'h13) and the instruction, PC, opinfo, imm and sys bus widths from the shared core package/defines, not from local literals.
REQ-032 SHALL hold storage as a DEPTH x DATA_W register array inline in stage_buf.
REQ-033 SHALL use one sub-module, stage_buf_ptr, a wrap-at-DEPTH pointer counter instantiated twice (read and write).
REQ-034 SHALL allow pipeline-stage wrappers (IF/ID, ID/EX) to concatenate their fields into in_data_i; those wrappers are outside this block.

Verification
REQ-035 SHALL be covered by a bench that applies reset, then checks: out_valid_o=0, out_data_o=32'h13, count_o=0, in_ready_o=1.
REQ-036 SHALL be covered by a bench that, with DEPTH=2 and RDY_PASS=0, pushes 32'hA, 32'hB while out_ready_i=0, and checks: count_o=2, in_ready_o=0, out_data_o=32'hA stable; then sets out_ready_i=1 and checks the pop order A then B.
REQ-037 SHALL be covered by a bench that, with DEPTH=3, streams 32'h1..32'h7 with random out_ready_i, and checks in-order output with no loss across pointer wrap.
REQ-038 SHALL be covered by a bench that, with DEPTH=1 and RDY_PASS=1, streams continuously with out_ready_i=1, and checks one beat per cycle with 1-cycle latency.
REQ-039 SHALL be covered by a bench that asserts flush_i with count_o=2 and in_valid_i=1, and checks: in_ready_o=0 that cycle; the next cycle count_o=0, out_data_o=32'h13, and the offered beat is lost.
REQ-040 SHALL be covered by a bench that asserts rst_i and flush_i together mid-stream, and checks the reset state of REQ-035 the next cycle.
